axis_hist_tx: RTL and testbench
===============================

AXIS_HIST_TX -- requirements
Module: axis_hist_tx

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 12'h020: storage base address of bin 0.
REQ-002 SHALL have parameter BIN_STRIDE, default 12'h020: address stride between consecutive bins.
REQ-003 SHALL use reset aresetn, synchronous, active-low, and clock aclk.
REQ-004 SHALL have port aclk  input  1  clock; all logic rising-edge.
REQ-005 SHALL have port aresetn  input  1  synchronous active-low reset.
REQ-006 SHALL have port s_axis_tdata  input  8  sample value.
REQ-007 SHALL have port s_axis_tvalid  input  1  sample valid.
REQ-008 SHALL have port s_axis_tready  output  1  sample accept.
REQ-009 SHALL have port m_axis_tdata  output  32  packet {header[31:28], count[27:20], bin_addr[19:8], value[7:0]}.
REQ-010 SHALL have port m_axis_tvalid  output  1  packet valid.
REQ-011 SHALL have port m_axis_tready  input  1  downstream (storage RAM) accept.
REQ-012 SHALL have port dump_req  input  1  single-cycle request to emit per-bin summary.
REQ-013 SHALL have port dump_done  output  1  one-cycle pulse after the last summary beat is accepted.
REQ-014 SHALL have port busy  output  1  high while in DUMP, or while a dump is pending.
REQ-015 SHALL have port sat_o  output  1  sticky flag: a bin counter hit 8'hFF (see Configuration).

Function
REQ-016 SHALL classify each sample into bin idx = value[7:5], bin_addr = BASE_ADDR + idx*BIN_STRIDE, truncated to 12 bits.
REQ-017 SHALL keep eight 8-bit bin counters and increment bin idx on every accepted sample.
REQ-018 SHALL emit data packet {4'b0000, post-increment count, bin_addr, value} registered, on the cycle after acceptance (latency 1).
REQ-019 SHALL drive s_axis_tready = (state==RUN) && !dump_pending && (!m_axis_tvalid || m_axis_tready).
REQ-020 SHALL hold m_axis_tdata and m_axis_tvalid stable while m_axis_tvalid && !m_axis_tready.
REQ-021 SHALL sustain one sample per cycle when m_axis_tready is held high.
REQ-022 SHALL have FSM states RUN and DUMP. RUN->DUMP occurs when dump_pending is set and the output register is empty or being drained this cycle. DUMP->RUN occurs when beat 7 is accepted.
REQ-023 SHALL latch dump_req into dump_pending. If dump_req and a sample acceptance coincide, SHALL count and emit the sample first, then dump.
REQ-024 SHALL ignore dump_req while in DUMP.
REQ-025 SHALL emit dump beats i=0..7 in order, as {4'b0010, counter_i, BASE_ADDR+i*BIN_STRIDE, 8'h00}, one beat per accepted handshake.
REQ-026 SHALL clear all counters and dump_pending, and pulse dump_done, in the cycle beat 7 is accepted.
REQ-027 SHALL use unsigned 8-bit counters; their overflow behaviour is set under Configuration.

Reset
REQ-028 SHALL, on aresetn low, clear all counters, dump_pending, dump_done, busy, sat_o, m_axis_tvalid and m_axis_tdata to 0, set state to RUN and set s_axis_tready to 1.
REQ-029 SHALL, on reset during DUMP, abandon the dump without asserting dump_done.

Configuration
REQ-030 SHALL, with HIST_SAT_EN defined, hold counters at 8'hFF on further increments (packet count stays 8'hFF) and set sat_o sticky until reset or dump completion.
REQ-031 SHALL, without HIST_SAT_EN, wrap counters 8'hFF->8'h00 and tie sat_o to 0.

Verification
REQ-032 Bench SHALL cover: samples 8'h05, 8'h25, 8'h07 with tready=1 -> 32'h0010_2005, 32'h0010_4025, 32'h0020_2007, each one cycle after acceptance.
REQ-033 Bench SHALL cover: m_axis_tready low for 3 cycles with a packet pending -> tdata/tvalid stable, s_axis_tready=0, no counter change.
REQ-034 Bench SHALL cover: dump_req asserted in the same cycle as acceptance of 8'hE1 -> packet 0x0011_00E1, then 8 beats 0x2xx_xx00 with bin 7 count=1, then dump_done pulse and all counters 0.
REQ-035 Bench SHALL cover: 256 samples of 8'h00 -> 256th packet count = 8'hFF and sat_o=1 with HIST_SAT_EN defined; count = 8'h00 and sat_o=0 without it.
REQ-036 Bench SHALL cover: aresetn low at dump beat 3 -> m_axis_tvalid=0 next cycle, no dump_done, state RUN, counters 0.

Source files
------------

// File: rtl/axis_hist_tx.sv
// Streaming 8-bin histogram: counts each sample, forwards a tagged packet, and dumps per-bin
// summaries on request. Define HIST_SAT_EN for saturating counters with sticky sat_o.
module axis_hist_tx #(
  parameter logic [11:0] BASE_ADDR  = 12'h020,
  parameter logic [11:0] BIN_STRIDE = 12'h020
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  output logic [31:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  input  logic        dump_req,
  output logic        dump_done,
  output logic        busy,
  output logic        sat_o
);

  typedef enum logic [0:0] {StRun, StDump} state_e;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q [8];
  logic [7:0]  cnt_d [8];
  logic        pending_q, pending_d;
  logic [2:0]  beat_q, beat_d;
  logic [31:0] tdata_q, tdata_d;
  logic        tvalid_q, tvalid_d;
  logic        done_q, done_d;
  logic        sat_q, sat_d;

  logic        out_free;
  logic        accept;
  logic [2:0]  sample_idx;
  logic [7:0]  inc_cnt;
  logic [2:0]  next_beat;

  function automatic logic [11:0] bin_addr(input logic [2:0] idx);
    bin_addr = BASE_ADDR + BIN_STRIDE * {9'd0, idx};
  endfunction

  // Output register can take a new word when empty or being drained this cycle.
  assign out_free      = !tvalid_q || m_axis_tready;
  assign s_axis_tready = (state_q == StRun) && !pending_q && out_free;
  assign accept        = s_axis_tready && s_axis_tvalid;
  assign sample_idx    = s_axis_tdata[7:5];
  assign next_beat     = beat_q + 3'd1;

`ifdef HIST_SAT_EN
  assign inc_cnt = (cnt_q[sample_idx] == 8'hFF) ? 8'hFF : cnt_q[sample_idx] + 8'd1;
`else
  assign inc_cnt = cnt_q[sample_idx] + 8'd1;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pending_d = pending_q;
    beat_d    = beat_q;
    tdata_d   = tdata_q;
    tvalid_d  = tvalid_q;
    done_d    = 1'b0;
    sat_d     = sat_q;

    if (tvalid_q && m_axis_tready) begin
      tvalid_d = 1'b0;
    end

    unique case (state_q)
      StRun: begin
        if (dump_req) begin
          pending_d = 1'b1;
        end
        if (accept) begin
          cnt_d[sample_idx] = inc_cnt;
          tdata_d  = {4'b0000, inc_cnt, bin_addr(sample_idx), s_axis_tdata};
          tvalid_d = 1'b1;
`ifdef HIST_SAT_EN
          if (inc_cnt == 8'hFF) begin
            sat_d = 1'b1;
          end
`endif
        end else if (pending_q && out_free) begin
          state_d  = StDump;
          beat_d   = 3'd0;
          tdata_d  = {4'b0010, cnt_q[0], bin_addr(3'd0), 8'h00};
          tvalid_d = 1'b1;
        end
      end
      StDump: begin
        // tvalid_q is always set in this state, so tready alone marks a beat handshake.
        if (m_axis_tready) begin
          if (beat_q == 3'd7) begin
            state_d   = StRun;
            tvalid_d  = 1'b0;
            pending_d = 1'b0;
            done_d    = 1'b1;
            sat_d     = 1'b0;
            for (int i = 0; i < 8; i++) begin
              cnt_d[i] = 8'h00;
            end
          end else begin
            beat_d   = next_beat;
            tdata_d  = {4'b0010, cnt_q[next_beat], bin_addr(next_beat), 8'h00};
            tvalid_d = 1'b1;
          end
        end
      end
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q   <= StRun;
      pending_q <= 1'b0;
      beat_q    <= 3'd0;
      tdata_q   <= 32'h0;
      tvalid_q  <= 1'b0;
      done_q    <= 1'b0;
      sat_q     <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        cnt_q[i] <= 8'h00;
      end
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      beat_q    <= beat_d;
      tdata_q   <= tdata_d;
      tvalid_q  <= tvalid_d;
      done_q    <= done_d;
      sat_q     <= sat_d;
      cnt_q     <= cnt_d;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign dump_done     = done_q;
  assign busy          = (state_q == StDump) || pending_q;
  assign sat_o         = sat_q;

endmodule

// File: tb/tb_axis_hist_tx.sv
// Scoreboard bench for axis_hist_tx: directed steps push expected packets, a negedge monitor
// pops them on each output handshake.
module tb_axis_hist_tx;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [7:0]  s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        dump_req;
  logic        dump_done;
  logic        busy;
  logic        sat_o;

  axis_hist_tx dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .dump_req      (dump_req),
    .dump_done     (dump_done),
    .busy          (busy),
    .sat_o         (sat_o)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t       exp_q[$];
  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  bit         mon_en = 1'b1;
  bit         lat_chk = 1'b1;
  logic [7:0] m_cnt [8];
  logic       m_sat;

  always @(posedge aclk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] m_addr(input int i);
    int a;
    a = 32'h020 + i * 32'h020;
    return a[11:0];
  endfunction

  // Output handshake happens on the next rising edge; inputs are stable by now.
  always @(negedge aclk) begin
    if (mon_en && aresetn && m_axis_tvalid && m_axis_tready) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_pkt", m_axis_tdata, 32'hxxxx_xxxx);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_pkt", m_axis_tdata, e.data);
        if (e.due >= 0) check("sb_latency", cyc, e.due);
      end
    end
  end

  task automatic model_clear();
    for (int i = 0; i < 8; i++) m_cnt[i] = 8'h00;
    m_sat = 1'b0;
  endtask

  // Caller is just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [7:0] v);
    int   n;
    bit   ok;
    int   idx;
    exp_t e;
    n  = 0;
    ok = 1'b0;
    idx = int'(v[7:5]);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = v;
    while (!ok && n < 50) begin
      @(negedge aclk);
      if (s_axis_tready) ok = 1'b1;
      else begin
        n++;
        @(posedge aclk);
        #1;
      end
    end
    if (!ok) begin
      check("send_timeout", 32'd0, 32'd1);
    end else begin
`ifdef HIST_SAT_EN
      if (m_cnt[idx] != 8'hFF) m_cnt[idx] = m_cnt[idx] + 8'd1;
      if (m_cnt[idx] == 8'hFF) m_sat = 1'b1;
`else
      m_cnt[idx] = m_cnt[idx] + 8'd1;
`endif
      e.data = {4'b0000, m_cnt[idx], m_addr(idx), v};
      e.due  = lat_chk ? cyc + 1 : -1;
      exp_q.push_back(e);
      @(posedge aclk);
      #1;
    end
    s_axis_tvalid = 1'b0;
  endtask

  task automatic dump_expect();
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      e.data = {4'b0010, m_cnt[i], m_addr(i), 8'h00};
      e.due  = -1;
      exp_q.push_back(e);
    end
    model_clear();
  endtask

  task automatic wait_done(input string tag);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge aclk);
      if (dump_done) found = 1'b1;
    end
    check({tag, "_done_seen"}, {31'd0, found}, 32'd1);
    check({tag, "_sb_drained"}, exp_q.size(), 32'd0);
    @(negedge aclk);
    check({tag, "_done_pulse_width"}, {31'd0, dump_done}, 32'd0);
    check({tag, "_busy_clear"}, {31'd0, busy}, 32'd0);
    @(posedge aclk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bit hit;
    int seen;
    model_clear();
    aresetn       = 1'b0;
    s_axis_tdata  = 8'h00;
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;
    dump_req      = 1'b0;
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    check("rst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    check("rst_tdata", m_axis_tdata, 32'h0);
    check("rst_s_tready", {31'd0, s_axis_tready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, dump_done}, 32'd0);
    check("rst_sat", {31'd0, sat_o}, 32'd0);
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    @(posedge aclk);
    #1;

    // Back-to-back stream with fixed expected packets.
    send(8'h05);
    @(negedge aclk);
    check("pkt_05", m_axis_tdata, 32'h0010_2005);
    @(posedge aclk);
    #1;
    send(8'h25);
    send(8'h07);
    @(negedge aclk);
    check("pkt_07", m_axis_tdata, 32'h0020_2007);
    @(posedge aclk);
    #1;

    // Downstream stall with a packet held in the output register.
    m_axis_tready = 1'b0;
    lat_chk = 1'b0;
    send(8'h45);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 8'h66;
    for (int i = 0; i < 3; i++) begin
      @(negedge aclk);
      check("stall_tdata", m_axis_tdata, 32'h0010_6045);
      check("stall_tvalid", {31'd0, m_axis_tvalid}, 32'd1);
      check("stall_s_tready", {31'd0, s_axis_tready}, 32'd0);
      @(posedge aclk);
      #1;
    end
    m_axis_tready = 1'b1;
    send(8'h66);
    lat_chk = 1'b1;

    // Dump request coinciding with acceptance of 0xE1.
    dump_req = 1'b1;
    send(8'hE1);
    dump_req = 1'b0;
    check("pkt_e1_model", {exp_q[exp_q.size()-1].data}, 32'h0011_00E1);
    dump_expect();
    @(negedge aclk);
    check("pkt_e1", m_axis_tdata, 32'h0011_00E1);
    check("dump_busy", {31'd0, busy}, 32'd1);
    check("dump_s_tready", {31'd0, s_axis_tready}, 32'd0);
    @(posedge aclk);
    #1;
    wait_done("dump1");

    // Counters must read back zero after a completed dump.
    dump_req = 1'b1;
    @(posedge aclk);
    #1;
    dump_req = 1'b0;
    dump_expect();
    wait_done("dump_zero");

    // 256 samples into bin 0: saturate or wrap depending on build.
    for (int i = 0; i < 256; i++) send(8'h00);
    @(negedge aclk);
`ifdef HIST_SAT_EN
    check("pkt_256", m_axis_tdata, 32'h0FF0_2000);
    check("sat_set", {31'd0, sat_o}, 32'd1);
`else
    check("pkt_256", m_axis_tdata, 32'h0000_2000);
    check("sat_tied", {31'd0, sat_o}, 32'd0);
`endif
    @(posedge aclk);
    #1;
    dump_req = 1'b1;
    @(posedge aclk);
    #1;
    dump_req = 1'b0;
    dump_expect();
    wait_done("dump_sat");
    check("sat_cleared", {31'd0, sat_o}, 32'd0);

    // Reset in the middle of a dump.
    send(8'h20);
    send(8'h20);
    dump_req = 1'b1;
    @(posedge aclk);
    #1;
    dump_req = 1'b0;
    mon_en = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      @(negedge aclk);
      if (m_axis_tvalid && m_axis_tdata[31:28] == 4'b0010 && m_axis_tdata[19:8] == m_addr(3))
        hit = 1'b1;
    end
    check("beat3_seen", {31'd0, hit}, 32'd1);
    aresetn = 1'b0;
    @(negedge aclk);
    check("rst_dump_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    check("rst_dump_done", {31'd0, dump_done}, 32'd0);
    check("rst_dump_busy", {31'd0, busy}, 32'd0);
    check("rst_dump_s_tready", {31'd0, s_axis_tready}, 32'd1);
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge aclk);
      if (dump_done) seen++;
    end
    check("rst_no_done", seen, 32'd0);
    @(posedge aclk);
    #1;
    exp_q.delete();
    model_clear();
    mon_en = 1'b1;
    dump_req = 1'b1;
    @(posedge aclk);
    #1;
    dump_req = 1'b0;
    dump_expect();
    wait_done("dump_after_rst");

    check("sb_final_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
